// File: rtl/seg_scan_capture.sv
// seg_scan_capture: receive-side monitor for a multiplexed 4-digit seven-segment bus.
// Waits for each active-low anode to settle, latches that digit's segment
// pattern, decodes it back to a hex nibble, and flags each complete frame.
// Optional feature macro: SEG_CAPTURE_SYNC_EN adds a two-flop synchronizer on
// an/segment for inputs arriving from package pins (adds 2 cycles of latency).
module seg_scan_capture #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  an,
    input  logic [7:0]  segment,
    output logic [31:0] digit_seg,
    output logic [15:0] hex,
    output logic [3:0]  dp_out,
    output logic [3:0]  digit_valid,
    output logic        frame_valid,
    output logic        scan_error,
    output logic        stale
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_HELD
    } state_t;

    // Glyph table lookup; dp is not part of the glyph. Returns {valid, nibble}.
    function automatic logic [4:0] decode(input logic [6:0] pattern);
        case (pattern)
            7'h40:   return 5'h10;
            7'h79:   return 5'h11;
            7'h24:   return 5'h12;
            7'h30:   return 5'h13;
            7'h19:   return 5'h14;
            7'h12:   return 5'h15;
            7'h02:   return 5'h16;
            7'h78:   return 5'h17;
            7'h00:   return 5'h18;
            7'h10:   return 5'h19;
            7'h08:   return 5'h1A;
            7'h03:   return 5'h1B;
            7'h46:   return 5'h1C;
            7'h21:   return 5'h1D;
            7'h06:   return 5'h1E;
            7'h0E:   return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    logic [3:0] an_s;
    logic [7:0] seg_s;

`ifdef SEG_CAPTURE_SYNC_EN
    logic [3:0] an_meta;
    logic [7:0] seg_meta;

    // Two-flop synchronizer; idles at all-ones so reset looks like blanking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_meta  <= '1;
            an_s     <= '1;
            seg_meta <= '1;
            seg_s    <= '1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, so the two stages really form a pipeline.
            an_meta  <= an;
            an_s     <= an_meta;
            seg_meta <= segment;
            seg_s    <= seg_meta;
        end
    end
`else
    assign an_s  = an;
    assign seg_s = segment;
`endif

    state_t          state, state_next;
    logic [CW-1:0]   count, count_next;
    logic [3:0]      an_prev;
    logic [TW-1:0]   idle_count;
    logic [3:0]      seen;

    logic            changed;
    logic            one_hot;
    logic            sample;
    logic            capture;
    logic            multi_low;
    logic            timeout_hit;
    logic [1:0]      digit_idx;
    logic [4:0]      decoded;
    logic [3:0]      seen_set;

    // Anode classification and the slot the current anode addresses.
    always_comb begin
        changed   = (an_s != an_prev);
        one_hot   = 1'b1;
        digit_idx = 2'd0;
        case (an_s)
            4'b1110: digit_idx = 2'd0;
            4'b1101: digit_idx = 2'd1;
            4'b1011: digit_idx = 2'd2;
            4'b0111: digit_idx = 2'd3;
            default: one_hot   = 1'b0;
        endcase
        decoded  = decode(seg_s[6:0]);
        seen_set = seen | (4'b0001 << digit_idx);
    end

    // Settle FSM next state. A change is evaluated on the very edge it is
    // seen, so the first edge showing a new anode counts as settle cycle 1.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        count_next = count;
        sample     = 1'b0;
        if (state == ST_WAIT || changed) begin
            if (an_s == 4'hF) begin
                state_next = ST_WAIT;
                count_next = '0;
            end else if (SETTLE_CYCLES == 1) begin
                sample     = 1'b1;
                state_next = ST_HELD;
                count_next = '0;
            end else begin
                state_next = ST_SETTLE;
                count_next = CW'(1);
            end
        end else if (state == ST_SETTLE) begin
            if (count + CW'(1) == SETTLE_LAST) begin
                sample     = 1'b1;
                state_next = ST_HELD;
                count_next = '0;
            end else begin
                count_next = count + CW'(1);
            end
        end
        // A multi-low pattern also parks in HELD, so it reports once and then
        // waits for the next anode change like a captured digit does.
        capture     = sample && one_hot;
        multi_low   = sample && !one_hot;
        timeout_hit = !capture && (idle_count == TIMEOUT_MAX - TW'(1));
    end

    // FSM state, settle counter and previous-anode register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_WAIT;
            count   <= '0;
            an_prev <= 4'hF;
        end else begin
            state   <= state_next;
            count   <= count_next;
            an_prev <= an_s;
        end
    end

    // Idle counter: cleared by every capture, saturates at the timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_count <= '0;
        end else if (capture) begin
            idle_count <= '0;
        end else if (idle_count != TIMEOUT_MAX) begin
            idle_count <= idle_count + TW'(1);
        end
    end

    // Captured slots, frame tracking and status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_seg   <= '1;
            hex         <= '0;
            dp_out      <= '0;
            digit_valid <= '0;
            frame_valid <= 1'b0;
            scan_error  <= 1'b0;
            stale       <= 1'b0;
            seen        <= '0;
        end else begin
            frame_valid <= 1'b0;
            scan_error  <= multi_low;
            if (capture) begin
                digit_seg[{digit_idx, 3'b000} +: 8] <= seg_s;
                hex[{digit_idx, 2'b00} +: 4]        <= decoded[3:0];
                digit_valid[digit_idx]              <= decoded[4];
                dp_out[digit_idx]                   <= ~seg_s[7];
                if (seen_set == 4'hF) begin
                    frame_valid <= 1'b1;
                    seen        <= '0;
                    stale       <= 1'b0;
                end else begin
                    seen <= seen_set;
                end
            end else if (timeout_hit) begin
                stale <= 1'b1;
                seen  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture (default build, synchronizer off).
// Reference model works on run lengths: a non-blank anode pattern is acted on
// when it has been present for exactly SETTLE consecutive edges.
module tb_seg_scan_capture;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  an;
    logic [7:0]  segment;
    logic [31:0] digit_seg;
    logic [15:0] hex;
    logic [3:0]  dp_out;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        scan_error;
    logic        stale;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_scan_capture #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .an         (an),
        .segment    (segment),
        .digit_seg  (digit_seg),
        .hex        (hex),
        .dp_out     (dp_out),
        .digit_valid(digit_valid),
        .frame_valid(frame_valid),
        .scan_error (scan_error),
        .stale      (stale)
    );

    // ---------------- reference model ----------------
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0]  m_last;
    int          m_run;
    logic [3:0]  m_seen;
    int          m_idle;
    logic [31:0] e_seg;
    logic [15:0] e_hex;
    logic [3:0]  e_dp, e_val;
    logic        e_frame, e_err, e_stale;

    task automatic model_reset();
        m_last = 4'hF; m_run = 0; m_seen = '0; m_idle = 0;
        e_seg = '1; e_hex = '0; e_dp = '0; e_val = '0;
        e_frame = 0; e_err = 0; e_stale = 0;
    endtask

    task automatic model_step(input logic [3:0] a, input logic [7:0] s);
        bit cap;
        int idx;
        cap = 0; idx = 0; e_frame = 0; e_err = 0;
        if (a == m_last) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run = 1;
        end
        m_last = a;
        if (a != 4'hF && m_run == SETTLE) begin
            if ($countones(~a) == 1) begin
                for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
                cap = 1;
                e_seg[idx*8 +: 8] = s;
                e_dp[idx] = !s[7];
                e_val[idx] = 1'b0;
                e_hex[idx*4 +: 4] = 4'h0;
                for (int g = 0; g < 16; g++)
                    if (glyph[g] == s[6:0]) begin
                        e_hex[idx*4 +: 4] = 4'(g);
                        e_val[idx] = 1'b1;
                    end
                m_seen[idx] = 1'b1;
            end else begin
                e_err = 1;
            end
        end
        if (cap) begin
            m_idle = 0;
            if (m_seen == 4'hF) begin
                e_frame = 1; m_seen = '0; e_stale = 0;
            end
        end else if (m_idle < TIMEOUT) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                e_stale = 1; m_seen = '0;
            end
        end
    endtask

    function automatic logic [58:0] obs_vec();
        return {digit_seg, hex, dp_out, digit_valid, frame_valid, scan_error, stale};
    endfunction

    function automatic logic [58:0] exp_vec();
        return {e_seg, e_hex, e_dp, e_val, e_frame, e_err, e_stale};
    endfunction

    // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic tick(input logic [3:0] a, input logic [7:0] s);
        an = a; segment = s;
        @(posedge clk);
        model_step(a, s);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; an = 4'hF; segment = 8'hFF;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0; an = 4'hF; segment = 8'hFF;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (digit_seg !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL reset_digit_seg got=%h exp=ffffffff", digit_seg);
        end
        checks++;
        if (hex !== 16'h0) begin
            errors++; $display("FAIL reset_hex got=%h exp=0000", hex);
        end
        checks++;
        if ({dp_out, digit_valid, frame_valid, scan_error, stale} !== 11'h0) begin
            errors++;
            $display("FAIL reset_flags got=%h exp=000", {dp_out, digit_valid, frame_valid, scan_error, stale});
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single_capture();
        for (int k = 1; k <= SETTLE; k++) begin
            tick(4'hE, 8'hB0);
            if (k < SETTLE) begin
                checks++;
                if (digit_seg !== 32'hFFFF_FFFF || digit_valid !== 4'h0) begin
                    errors++; $display("FAIL single_early tick=%0d got=%h exp=ffffffff", k, digit_seg);
                end
            end
        end
        checks++;
        if (hex[3:0] !== 4'h3 || digit_valid[0] !== 1'b1 || dp_out[0] !== 1'b0 || digit_seg[7:0] !== 8'hB0) begin
            errors++;
            $display("FAIL single_capture got hex=%h val=%b dp=%b seg=%h exp hex=3 val=1 dp=0 seg=b0",
                     hex[3:0], digit_valid[0], dp_out[0], digit_seg[7:0]);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL single_model got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_frame_scan();
        logic [7:0] pat [4] = '{8'h79, 8'h24, 8'h30, 8'h19};
        logic [3:0] sel [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        int frames, frame_at;
        frames = 0; frame_at = -1;
        tick(4'hF, 8'hFF);
        for (int d = 0; d < 4; d++)
            for (int k = 0; k < 8; k++) begin
                tick(sel[d], pat[d]);
                if (frame_valid === 1'b1) begin frames++; frame_at = d*8 + k; end
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++; $display("FAIL frame_model d=%0d k=%0d got=%h exp=%h", d, k, obs_vec(), exp_vec());
                end
            end
        checks++;
        if (frames !== 1 || frame_at !== 27) begin
            errors++; $display("FAIL frame_pulse got count=%0d at=%0d exp count=1 at=27", frames, frame_at);
        end
        checks++;
        if (hex !== 16'h4321 || digit_valid !== 4'hF) begin
            errors++; $display("FAIL frame_hex got=%h/%b exp=4321/1111", hex, digit_valid);
        end
    endtask

    task automatic test_glitch();
        tick(4'hF, 8'hFF);
        tick(4'hE, 8'h40);
        tick(4'hE, 8'h40);
        for (int k = 1; k <= 5; k++) begin
            tick(4'hD, 8'h02);
            if (k == SETTLE - 1) begin
                checks++;
                if (digit_seg[15:8] !== 8'h24) begin
                    errors++; $display("FAIL glitch_early got=%h exp=24", digit_seg[15:8]);
                end
            end
            if (k == SETTLE) begin
                checks++;
                if (digit_seg[15:8] !== 8'h02 || hex[7:4] !== 4'h6) begin
                    errors++; $display("FAIL glitch_capture got=%h/%h exp=02/6", digit_seg[15:8], hex[7:4]);
                end
            end
        end
        checks++;
        if (digit_seg[7:0] !== 8'h79) begin
            errors++; $display("FAIL glitch_no_digit0 got=%h exp=79", digit_seg[7:0]);
        end
    endtask

    task automatic test_scan_error();
        logic [31:0] saved;
        int errs, err_at;
        tick(4'hF, 8'hFF);
        saved = digit_seg; errs = 0; err_at = -1;
        for (int k = 1; k <= 10; k++) begin
            tick(4'hC, 8'($urandom));
            if (scan_error === 1'b1) begin errs++; err_at = k; end
        end
        checks++;
        if (errs !== 1 || err_at !== SETTLE) begin
            errors++; $display("FAIL scan_error_pulse got count=%0d at=%0d exp count=1 at=%0d", errs, err_at, SETTLE);
        end
        checks++;
        if (digit_seg !== saved) begin
            errors++; $display("FAIL scan_error_nocap got=%h exp=%h", digit_seg, saved);
        end
        errs = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(4'hF, 8'($urandom));
            if (scan_error === 1'b1) errs++;
        end
        checks++;
        if (errs !== 0 || digit_seg !== saved) begin
            errors++; $display("FAIL blank_quiet got errs=%0d seg=%h exp errs=0 seg=%h", errs, digit_seg, saved);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL scan_error_model got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_invalid_glyph();
        tick(4'hF, 8'hFF);
        repeat (5) tick(4'hB, 8'h7F);
        checks++;
        if (digit_seg[23:16] !== 8'h7F || hex[11:8] !== 4'h0 || digit_valid[2] !== 1'b0) begin
            errors++;
            $display("FAIL invalid_glyph got seg=%h hex=%h val=%b exp seg=7f hex=0 val=0",
                     digit_seg[23:16], hex[11:8], digit_valid[2]);
        end
        tick(4'hF, 8'hFF);
        repeat (5) tick(4'hB, 8'h00);
        checks++;
        if (dp_out[2] !== 1'b1 || hex[11:8] !== 4'h8 || digit_valid[2] !== 1'b1) begin
            errors++;
            $display("FAIL dp_eight got dp=%b hex=%h val=%b exp dp=1 hex=8 val=1", dp_out[2], hex[11:8], digit_valid[2]);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] pat [4] = '{8'hA4, 8'hB0, 8'hC0, 8'hF9};
        logic [3:0] sel [4] = '{4'hB, 4'h7, 4'hE, 4'hD};
        int frames, frame_at;
        do_reset();
        tick(4'hF, 8'hFF);
        repeat (4) tick(4'hE, 8'hC0);
        tick(4'hF, 8'hFF);
        repeat (4) tick(4'hD, 8'hF9);
        repeat (TIMEOUT - 1) tick(4'hF, 8'hFF);
        checks++;
        if (stale !== 1'b0) begin
            errors++; $display("FAIL stale_early got=%b exp=0", stale);
        end
        tick(4'hF, 8'hFF);
        checks++;
        if (stale !== 1'b1) begin
            errors++; $display("FAIL stale_set got=%b exp=1", stale);
        end
        frames = 0; frame_at = -1;
        for (int d = 0; d < 4; d++)
            for (int k = 0; k < 8; k++) begin
                tick(sel[d], pat[d]);
                if (frame_valid === 1'b1) begin frames++; frame_at = d*8 + k; end
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++; $display("FAIL timeout_model d=%0d k=%0d got=%h exp=%h", d, k, obs_vec(), exp_vec());
                end
            end
        checks++;
        if (frames !== 1 || frame_at !== 27 || stale !== 1'b0) begin
            errors++;
            $display("FAIL timeout_frame got count=%0d at=%0d stale=%b exp count=1 at=27 stale=0", frames, frame_at, stale);
        end
    endtask

    task automatic test_reset_mid_scan();
        tick(4'hF, 8'hFF);
        repeat (5) tick(4'hE, 8'h40);
        repeat (3) tick(4'hD, 8'h79);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({digit_seg, hex, dp_out, digit_valid, frame_valid, scan_error, stale} !== {32'hFFFF_FFFF, 27'h0}) begin
            errors++;
            $display("FAIL mid_reset got=%h exp=%h", obs_vec(), {32'hFFFF_FFFF, 27'h0});
        end
        do_reset();
        repeat (SETTLE) tick(4'hE, 8'hC0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL mid_reset_restart got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [7:0] s;
        int r, len;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                a = 4'hF;
            end else if (r < 8) begin
                case ($urandom_range(0, 3))
                    0: a = 4'hE;
                    1: a = 4'hD;
                    2: a = 4'hB;
                    default: a = 4'h7;
                endcase
            end else begin
                a = 4'($urandom);
                while ($countones(~a) < 2) a = 4'($urandom);
            end
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                if (k == 0 || $urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 3) != 0) s = {1'($urandom), glyph[$urandom_range(0, 15)]};
                    else s = 8'($urandom);
                end
                tick(a, s);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++; $display("FAIL random_model n=%0d an=%h seg=%h got=%h exp=%h", n, a, s, obs_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_frame_scan();
        test_glitch();
        test_scan_error();
        test_invalid_glyph();
        test_timeout();
        test_reset_mid_scan();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
